// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its async fetch path / output consumer.
// Latency: none (wires only).
// Backpressure: carries the out_valid/out_ready handshake and the four-phase ack lines.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
);
    // control from synchronous logic
    logic               run;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_init;
    logic               err_clr;
    // requests towards the async fetch path
    logic [ADDR_W-1:0]  addr;
    logic [1:0]         ph0;
    logic [1:0]         ph1;
    logic               instr_ack_next;
    // acks and bundled data from the async fetch path
    logic               mem_addr_ack;
    logic               ctrl_ack;
    logic               instr_ack_before;
    logic [INSTR_W-1:0] instruction;
    // captured-instruction stream
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_addr;
    logic               out_valid;
    logic               out_ready;
    // status
    logic               busy;
    logic               timeout_err;

    modport master (
        input  run, pc_load, pc_init, err_clr,
        input  mem_addr_ack, ctrl_ack, instr_ack_before, instruction,
        input  out_ready,
        output addr, ph0, ph1, instr_ack_next,
        output out_instr, out_addr, out_valid,
        output busy, timeout_err
    );

    modport slave (
        output run, pc_load, pc_init, err_clr,
        output mem_addr_ack, ctrl_ack, instr_ack_before, instruction,
        output out_ready,
        input  addr, ph0, ph1, instr_ack_next,
        input  out_instr, out_addr, out_valid,
        input  busy, timeout_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Drives four-phase dual-rail fetch handshakes into the async path and captures each instruction.
// Latency: 1 + 4*(SYNC_STAGES+1) + 2 cycles per fetch with instant acks (15 at defaults).
// Backpressure: single output register; no new fetch starts while an unaccepted word is held.
module fetch_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int INSTR_W     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.master fif
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR_SETUP = 4'd1;
    localparam logic [3:0] S_ADDR_REQ   = 4'd2;
    localparam logic [3:0] S_ADDR_RTZ   = 4'd3;
    localparam logic [3:0] S_LATCH_REQ  = 4'd4;
    localparam logic [3:0] S_CAPTURE    = 4'd5;
    localparam logic [3:0] S_INSTR_ACK  = 4'd6;
    localparam logic [3:0] S_ACK_RTZ    = 4'd7;
    localparam logic [3:0] S_ERROR      = 4'd8;

    localparam logic [1:0] PH_SPACER = 2'b00;
    localparam logic [1:0] PH_TOKEN  = 2'b10;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_m;
    logic [SYNC_STAGES-1:0] sync_c;
    logic [SYNC_STAGES-1:0] sync_i;
    logic                   a_m;
    logic                   a_c;
    logic                   a_i;

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timed_out;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;

    assign a_m = sync_m[SYNC_STAGES-1];
    assign a_c = sync_c[SYNC_STAGES-1];
    assign a_i = sync_i[SYNC_STAGES-1];

    // Last cycle allowed in an ack-wait state; only consulted when the exit condition is false
    assign timed_out = (wait_cnt == CNT_LAST);

    assign fif.busy = (state != S_IDLE) && (state != S_ERROR);

    // Bring the three asynchronous acks into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_m <= '0;
            sync_c <= '0;
            sync_i <= '0;
        end else begin
            sync_m <= {sync_m[SYNC_STAGES-2:0], fif.mem_addr_ack};
            sync_c <= {sync_c[SYNC_STAGES-2:0], fif.ctrl_ack};
            sync_i <= {sync_i[SYNC_STAGES-2:0], fif.instr_ack_before};
        end
    end

    // Handshake sequencing; ADDR_RTZ also waits for a_i low so a responder still holding
    // its instruction ack after a reset cannot be mistaken for a completed latch
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (fif.run && !fif.out_valid) state_nxt = S_ADDR_SETUP;
            S_ADDR_SETUP: state_nxt = S_ADDR_REQ;
            S_ADDR_REQ: begin
                if (a_m && a_c)     state_nxt = S_ADDR_RTZ;
                else if (timed_out) state_nxt = S_ERROR;
            end
            S_ADDR_RTZ: begin
                if (!a_m && !a_c && !a_i) state_nxt = S_LATCH_REQ;
                else if (timed_out)       state_nxt = S_ERROR;
            end
            S_LATCH_REQ: begin
                if (a_i)            state_nxt = S_CAPTURE;
                else if (timed_out) state_nxt = S_ERROR;
            end
            S_CAPTURE:    state_nxt = S_INSTR_ACK;
            S_INSTR_ACK: begin
                if (!a_i)           state_nxt = S_ACK_RTZ;
                else if (timed_out) state_nxt = S_ERROR;
            end
            S_ACK_RTZ: begin
                if (fif.run && (!fif.out_valid || fif.out_ready)) state_nxt = S_ADDR_SETUP;
                else if (!fif.run)                                state_nxt = S_IDLE;
            end
            S_ERROR:      if (fif.err_clr) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // pc advances once per completed fetch (on entry to ACK_RTZ) and loads only when not busy
    always_comb begin
        pc_nxt = pc;
        if (state == S_INSTR_ACK && state_nxt == S_ACK_RTZ) begin
            pc_nxt = pc + 1'b1;
        end else if (fif.pc_load && (state == S_IDLE || state == S_ERROR)) begin
            pc_nxt = fif.pc_init;
        end
    end

    // State, pc and the per-state wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_SAT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Async-facing outputs are registered from the next state so they never glitch;
    // addr settles on entry to ADDR_SETUP, one full cycle ahead of the ph0 token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fif.addr           <= '0;
            fif.ph0            <= PH_SPACER;
            fif.ph1            <= PH_SPACER;
            fif.instr_ack_next <= 1'b0;
            fif.timeout_err    <= 1'b0;
        end else begin
            fif.ph0            <= (state_nxt == S_ADDR_REQ) ? PH_TOKEN : PH_SPACER;
            fif.ph1            <= (state_nxt == S_LATCH_REQ || state_nxt == S_CAPTURE)
                                  ? PH_TOKEN : PH_SPACER;
            fif.instr_ack_next <= (state_nxt == S_INSTR_ACK);
            fif.timeout_err    <= (state_nxt == S_ERROR);
            if (state_nxt == S_ADDR_SETUP) begin
                fif.addr <= pc_nxt;
            end
        end
    end

    // Output word register; a capture in the same cycle as an accept keeps the word valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fif.out_instr <= '0;
            fif.out_addr  <= '0;
            fif.out_valid <= 1'b0;
        end else if (state == S_CAPTURE) begin
            fif.out_instr <= fif.instruction;
            fif.out_addr  <= fif.addr;
            fif.out_valid <= 1'b1;
        end else if (fif.out_valid && fif.out_ready) begin
            fif.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised bench: behavioural async responder with random ack delays plus an address/data scoreboard.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, timeouts, reset mid-handshake and run drop.
module tb_fetch_sequencer;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 16;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) fif ();

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fif(fif)
    );

    logic [INSTR_W-1:0] mem [16];
    int n_vec = 0;
    int n_err = 0;
    int n_words = 0;
    logic [ADDR_W-1:0] load_val = '0;
    int load_seq = 0;
    logic withhold_m = 1'b0;
    logic force_i = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph0(input logic [1:0] v, input string tag);
        int g = 0;
        while (fif.ph0 != v && g < 400) begin tick(); g++; end
        check_eq(tag, 32'(fif.ph0), 32'(v));
    endtask

    task automatic wait_ph1(input logic [1:0] v, input string tag);
        int g = 0;
        while (fif.ph1 != v && g < 400) begin tick(); g++; end
        check_eq(tag, 32'(fif.ph1), 32'(v));
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!fif.out_valid && g < 400) begin tick(); g++; end
        check_eq(tag, 32'(fif.out_valid), 1);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((fif.busy || fif.out_valid) && g < 400) begin tick(); g++; end
        check_eq(tag, 32'(fif.busy || fif.out_valid), 0);
    endtask

    task automatic wait_words(input int target, input string tag);
        int g = 0;
        while (n_words < target && g < 1000) begin tick(); g++; end
        check_eq(tag, 32'(n_words >= target), 1);
    endtask

    task automatic load_pc(input logic [ADDR_W-1:0] v);
        fif.pc_init = v;
        fif.pc_load = 1'b1;
        load_val = v;
        load_seq++;
    endtask

    // Async path model: acks follow the tokens after a random 0..3 cycle delay;
    // instruction is valid only while instr_ack_before is high, garbage otherwise
    initial begin : responder
        int dly_m = 0;
        int dly_c = 0;
        int dly_i = 0;
        logic want_m, want_c, want_i;
        fif.mem_addr_ack = 1'b0;
        fif.ctrl_ack = 1'b0;
        fif.instr_ack_before = 1'b0;
        fif.instruction = '0;
        forever begin
            @(posedge clk);
            #1;
            want_m = (fif.ph0 == 2'b10) && !withhold_m;
            want_c = (fif.ph0 == 2'b10);
            want_i = (fif.ph1 == 2'b10) || force_i;
            if (fif.mem_addr_ack != want_m) begin
                if (dly_m == 0) begin
                    fif.mem_addr_ack = want_m;
                    dly_m = int'($urandom_range(0, 3));
                end else dly_m--;
            end
            if (fif.ctrl_ack != want_c) begin
                if (dly_c == 0) begin
                    fif.ctrl_ack = want_c;
                    dly_c = int'($urandom_range(0, 3));
                end else dly_c--;
            end
            if (fif.instr_ack_before != want_i) begin
                if (dly_i == 0) begin
                    if (want_i) fif.instruction = mem[fif.addr];
                    fif.instr_ack_before = want_i;
                    dly_i = int'($urandom_range(0, 3));
                end else dly_i--;
            end
            if (!fif.instr_ack_before) fif.instruction = INSTR_W'($urandom);
        end
    end

    // Protocol monitor and scoreboard: consecutive fetch addresses, word = mem[address]
    initial begin : monitor
        logic [ADDR_W-1:0] sb_pc = '0;
        logic [ADDR_W-1:0] tok_addr = '0;
        int seen_seq = 0;
        logic prev_tok = 1'b0;
        forever begin
            @(negedge clk);
            if (load_seq != seen_seq) begin
                sb_pc = load_val;
                seen_seq = load_seq;
            end
            if (rst_n) begin
                check_eq("ph0_enc", 32'(fif.ph0 == 2'b00 || fif.ph0 == 2'b10), 1);
                check_eq("ph1_enc", 32'(fif.ph1 == 2'b00 || fif.ph1 == 2'b10), 1);
                check_eq("ph_overlap", 32'(fif.ph0 == 2'b10 && fif.ph1 == 2'b10), 0);
                if (fif.ph0 == 2'b10) begin
                    if (!prev_tok) tok_addr = fif.addr;
                    else check_eq("addr_bundle", 32'(fif.addr), 32'(tok_addr));
                end
                prev_tok = (fif.ph0 == 2'b10);
                if (fif.out_valid && fif.out_ready) begin
                    check_eq("sb_addr", 32'(fif.out_addr), 32'(sb_pc));
                    check_eq("sb_instr", 32'(fif.out_instr), 32'(mem[sb_pc]));
                    sb_pc = sb_pc + 1'b1;
                    n_words++;
                end
            end else begin
                prev_tok = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int n_tok;
        int n_chg;
        int n_nb;
        int g;
        logic [INSTR_W-1:0] w;

        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[3] = 16'hA55A;
        mem[6] = ~mem[5];

        fif.run = 1'b0;
        fif.pc_load = 1'b0;
        fif.pc_init = '0;
        fif.err_clr = 1'b0;
        fif.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();

        // reset values
        check_eq("rst_addr", 32'(fif.addr), 0);
        check_eq("rst_ph0", 32'(fif.ph0), 0);
        check_eq("rst_ph1", 32'(fif.ph1), 0);
        check_eq("rst_ack_next", 32'(fif.instr_ack_next), 0);
        check_eq("rst_out_instr", 32'(fif.out_instr), 0);
        check_eq("rst_out_addr", 32'(fif.out_addr), 0);
        check_eq("rst_out_valid", 32'(fif.out_valid), 0);
        check_eq("rst_timeout", 32'(fif.timeout_err), 0);
        check_eq("rst_busy", 32'(fif.busy), 0);
        rst_n = 1'b1;
        tick();

        // first fetch from pc 3, then the next one at 4
        fif.out_ready = 1'b1;
        load_pc(4'h3);
        fif.run = 1'b1;
        tick();
        fif.pc_load = 1'b0;
        wait_ph0(2'b10, "t1_req");
        check_eq("t1_addr", 32'(fif.addr), 3);
        wait_valid("t1_valid");
        check_eq("t1_instr", 32'(fif.out_instr), 32'h0000A55A);
        check_eq("t1_out_addr", 32'(fif.out_addr), 3);
        wait_ph0(2'b10, "t1_next_req");
        check_eq("t1_next_addr", 32'(fif.addr), 4);
        fif.run = 1'b0;
        wait_idle("t1_idle");

        // continuous run across the address wrap; pc_load while busy is ignored
        load_pc(4'hE);
        fif.run = 1'b1;
        tick();
        fif.pc_load = 1'b0;
        base = n_words;
        wait_words(base + 2, "t2_w2");
        check_eq("t2_busy", 32'(fif.busy), 1);
        fif.pc_init = 4'h7;
        fif.pc_load = 1'b1;
        tick();
        fif.pc_load = 1'b0;
        wait_words(base + 4, "t2_w4");
        fif.run = 1'b0;
        wait_idle("t2_idle");

        // random downstream readiness while running
        base = n_words;
        fif.run = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fif.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        fif.out_ready = 1'b1;
        fif.run = 1'b0;
        wait_idle("t2b_idle");
        check_eq("t2b_progress", 32'(n_words - base >= 3), 1);

        // backpressure: held word blocks the next fetch
        fif.out_ready = 1'b0;
        load_pc(4'h5);
        fif.run = 1'b1;
        tick();
        fif.pc_load = 1'b0;
        wait_valid("t3_valid");
        w = fif.out_instr;
        n_tok = 0; n_chg = 0; n_nb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fif.ph0 != 2'b00) n_tok++;
            if (fif.out_instr != w) n_chg++;
            if (!fif.busy) n_nb++;
        end
        check_eq("t3_no_token", 32'(n_tok), 0);
        check_eq("t3_word_held", 32'(n_chg), 0);
        check_eq("t3_busy", 32'(n_nb), 0);
        check_eq("t3_valid_held", 32'(fif.out_valid), 1);
        base = n_words;
        fif.out_ready = 1'b1;
        n_chg = 0;
        g = 0;
        while (n_words < base + 2 && g < 400) begin
            tick();
            if (fif.out_instr != w) begin n_chg++; w = fif.out_instr; end
            g++;
        end
        check_eq("t3_resume", 32'(n_words >= base + 2), 1);
        check_eq("t3_one_update", 32'(n_chg), 1);
        fif.run = 1'b0;
        wait_idle("t3_idle");

        // withheld mem_addr_ack -> timeout after TIMEOUT cycles of token
        withhold_m = 1'b1;
        load_pc(4'h9);
        fif.run = 1'b1;
        tick();
        fif.pc_load = 1'b0;
        n_tok = 0;
        g = 0;
        while (!fif.timeout_err && g < 600) begin
            if (fif.ph0 == 2'b10) n_tok++;
            tick();
            g++;
        end
        check_eq("t4_timeout_err", 32'(fif.timeout_err), 1);
        check_eq("t4_token_cycles", 32'(n_tok), TIMEOUT);
        check_eq("t4_ph0", 32'(fif.ph0), 0);
        check_eq("t4_ph1", 32'(fif.ph1), 0);
        check_eq("t4_busy", 32'(fif.busy), 0);
        fif.run = 1'b0;
        withhold_m = 1'b0;
        repeat (5) tick();
        check_eq("t4_sticky", 32'(fif.timeout_err), 1);
        fif.err_clr = 1'b1;
        load_pc(4'hC);
        tick();
        fif.err_clr = 1'b0;
        fif.pc_load = 1'b0;
        check_eq("t4_clr", 32'(fif.timeout_err), 0);
        check_eq("t4_clr_busy", 32'(fif.busy), 0);
        base = n_words;
        fif.run = 1'b1;
        wait_words(base + 1, "t4_recover");
        fif.run = 1'b0;
        wait_idle("t4_idle");

        // reset during LATCH_REQ with the responder holding its instruction ack
        fif.run = 1'b1;
        wait_ph1(2'b10, "t5_latch");
        force_i = 1'b1;
        rst_n = 1'b0;
        fif.run = 1'b0;
        #1;
        check_eq("t5_ph1", 32'(fif.ph1), 0);
        check_eq("t5_ph0", 32'(fif.ph0), 0);
        check_eq("t5_valid", 32'(fif.out_valid), 0);
        check_eq("t5_busy", 32'(fif.busy), 0);
        check_eq("t5_addr", 32'(fif.addr), 0);
        tick();
        tick();
        load_val = '0;
        load_seq++;
        rst_n = 1'b1;
        fif.run = 1'b1;
        n_chg = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fif.out_valid) n_chg++;
        end
        check_eq("t5_no_capture", 32'(n_chg), 0);
        check_eq("t5_waiting", 32'(fif.busy), 1);
        base = n_words;
        force_i = 1'b0;
        wait_words(base + 1, "t5_recover");
        fif.run = 1'b0;
        wait_idle("t5_idle");

        // run dropped during ADDR_RTZ: fetch completes, then stays idle
        fif.run = 1'b1;
        wait_ph0(2'b10, "t6_req");
        wait_ph0(2'b00, "t6_rtz");
        fif.run = 1'b0;
        wait_valid("t6_valid");
        wait_idle("t6_idle");
        n_tok = 0; n_nb = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (fif.ph0 != 2'b00) n_tok++;
            if (fif.busy) n_nb++;
        end
        check_eq("t6_no_token", 32'(n_tok), 0);
        check_eq("t6_not_busy", 32'(n_nb), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Clocked environment and consumer for the asynchronous fetch path: cpu top-level with est_controller, mem_addr_mux, memory and instr_reg.
- Drives the addresses and the PH0/PH1 dual-rail phase tokens into that path.
- Runs the four-phase return-to-zero handshakes against its acks.
- Captures each fetched instruction and hands it to synchronous logic through a valid/ready port.
- Acts as the initiator/consumer end of the protocol whose responder is the async fetch path.

Parameters:
- ADDR_W, 4, address width (matches the fetch path's addr input)
- INSTR_W, 16, instruction width
- SYNC_STAGES, 2, flip-flop stages on each incoming ack (minimum 2)
- TIMEOUT, 255, maximum cycles spent in any ack-wait state before error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = fetch continuously, 0 = stop after the current fetch completes
- pc_load  in  1  pulse; load pc from pc_init (accepted only in IDLE or ERROR)
- pc_init  in  ADDR_W  start address
- err_clr  in  1  pulse; clear timeout_err, ERROR -> IDLE
- addr  out  ADDR_W  fetch address to the async path
- ph0  out  2  dual-rail address-phase token
- ph1  out  2  dual-rail instruction-latch token
- instr_ack_next  out  1  consumer ack to the instruction register
- mem_addr_ack  in  1  async ack from the address mux
- ctrl_ack  in  1  async ack from the controller
- instr_ack_before  in  1  async completion from the instruction register
- instruction  in  INSTR_W  bundled data, stable while instr_ack_before = 1
- out_instr  out  INSTR_W  captured instruction
- out_addr  out  ADDR_W  address it was fetched from
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  downstream accepts
- busy  out  1  state != IDLE and != ERROR
- timeout_err  out  1  sticky handshake timeout

Behaviour:
- Dual-rail encoding on ph0/ph1:
  - 2'b00 = spacer
  - 2'b10 = token
  - 2'b01 = false data; never driven
  - 2'b11 = illegal; never driven
- Ack synchronisation:
  - All three acks pass through SYNC_STAGES flops.
  - The FSM uses only the synchronised values (a_m, a_c, a_i).
- Reset values: addr = 0, pc = 0, ph0 = ph1 = 00, instr_ack_next = 0, out_instr = 0, out_addr = 0, out_valid = 0, timeout_err = 0, state = IDLE.
- Reset mid-handshake forces spacers immediately. The async path must return its acks to 0 before the next run; the first wait-low state enforces this.
- FSM states and transitions:
  - IDLE: busy = 0. run = 1 and out_valid = 0 -> ADDR_SETUP.
  - ADDR_SETUP: addr <= pc, ph0 = 00, for 1 cycle (bundling setup) -> ADDR_REQ.
  - ADDR_REQ: ph0 = 10. Wait a_m & a_c -> ADDR_RTZ.
  - ADDR_RTZ: ph0 = 00. Wait !a_m & !a_c -> LATCH_REQ.
  - LATCH_REQ: ph1 = 10. Wait a_i -> CAPTURE.
  - CAPTURE: 1 cycle. out_instr <= instruction, out_addr <= addr, out_valid <= 1 -> INSTR_ACK.
  - INSTR_ACK: ph1 = 00, instr_ack_next = 1. Wait !a_i -> ACK_RTZ.
  - ACK_RTZ: instr_ack_next = 0, pc <= pc + 1 (wraps 2^ADDR_W-1 -> 0). Next state:
    - run = 1 and (out_valid = 0 or out_ready = 1) -> ADDR_SETUP
    - run = 0 -> IDLE
    - otherwise stay (backpressure)
  - ERROR: ph0 = ph1 = 00, instr_ack_next = 0, timeout_err = 1. err_clr -> IDLE.
- Output handshake:
  - out_valid clears on out_valid & out_ready, unless CAPTURE sets it in the same cycle; set wins.
  - There is a single output register. A new fetch does not start while an un-accepted word is held.
- Timeout:
  - A counter resets on every state change.
  - Reaching TIMEOUT in ADDR_REQ, ADDR_RTZ, LATCH_REQ or INSTR_ACK -> ERROR.
  - out_valid is preserved on entry to ERROR.
- pc_load in a busy state is ignored. pc_load and err_clr in the same cycle: both take effect.
- run falling mid-fetch: the current fetch completes; then IDLE.
- Minimum fetch cycle with acks arriving instantly (raw ack one cycle after the request): 1 + 4×(SYNC_STAGES + 1) + 2 cycles = 15 cycles at defaults.

Test Plan:
- Reset, then pc_init = 4'h3 + pc_load, run = 1, responder model acks after 3 cycles, instruction = 16'hA55A -> ph0 goes 00 -> 10 -> 00 with addr = 3 held; out_valid = 1 with out_instr = A55A, out_addr = 3; next fetch at addr = 4.
- Continuous run from pc = 4'hE with out_ready = 1 -> out_addr sequence E, F, 0, 1 (wrap); ph0 and ph1 never 11 or 01; ph1 never 10 while ph0 = 10.
- out_ready = 0 for 40 cycles after the first capture -> second fetch not started (ph0 stays 00, busy = 1 in ACK_RTZ); release -> fetch resumes at pc + 1, out_instr updates exactly once.
- Responder withholds mem_addr_ack -> after 255 cycles in ADDR_REQ: timeout_err = 1, ph0 = 00, busy = 0; err_clr -> IDLE, timeout_err = 0.
- Assert rst_n low while in LATCH_REQ -> same-cycle ph1 = 00, out_valid = 0, pc = 0; responder holding a_i = 1 after reset -> no capture until a full valid handshake.
- run dropped during ADDR_RTZ -> that fetch completes (out_valid = 1), then IDLE with busy = 0 and no further ph0 tokens.
